// File: rtl/ls_queue.sv
// In-order load/store queue: snoops the CDB for pending operands and feeds the
// head op to data memory (store write/finish handshake, combinational load read).
module ls_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned ADDR_W = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iss_valid,
    output logic                     iss_ready,
    input  logic                     iss_is_store,
    input  logic [31:0]              iss_base,
    input  logic [TAG_W-1:0]         iss_base_tag,
    input  logic [31:0]              iss_data,
    input  logic [TAG_W-1:0]         iss_data_tag,
    input  logic [15:0]              iss_offset,
    input  logic [TAG_W-1:0]         iss_tag,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [31:0]              cdb_data,
    output logic                     mem_wena,
    output logic [ADDR_W-1:0]        mem_addrS,
    output logic [31:0]              mem_wdata,
    output logic [ADDR_W-1:0]        mem_addrL,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_fns,
    output logic                     out_valid,
    output logic [TAG_W-1:0]         out_tag,
    output logic [31:0]              out_data,
    input  logic                     out_grant,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic             valid;
        logic             is_store;
        logic [31:0]      base;
        logic [TAG_W-1:0] base_tag;
        logic [31:0]      data;
        logic [TAG_W-1:0] data_tag;
        logic [15:0]      offset;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic [2:0] {IDLE, ST_WR, ST_WAIT, LD_RD, LD_OUT} state_t;

    entry_t            q [DEPTH];
    entry_t            head_e;
    entry_t            push_e;
    logic [PTR_W-1:0]  head, tail;
    state_t            state, state_nxt;
    logic              head_rdy, push, pop;
    logic [ADDR_W-1:0] ea_addr;
    logic [CNT_W-1:0]  count_nxt;

    logic              wena_nxt, ov_nxt;
    logic [ADDR_W-1:0] addrs_nxt, addrl_nxt;
    logic [31:0]       wdata_nxt, odata_nxt;
    logic [TAG_W-1:0]  otag_nxt;

    // Head decode and effective address (word index, upper EA bits dropped)
    always_comb begin
        head_e   = q[head];
        head_rdy = head_e.valid && (head_e.base_tag == '0)
                   && (!head_e.is_store || (head_e.data_tag == '0));
        ea_addr  = ADDR_W'(head_e.base + {{16{head_e.offset[15]}}, head_e.offset});
    end

    // Incoming entry, with same-cycle CDB bypass on either operand
    always_comb begin
        push      = iss_valid && iss_ready;
        count_nxt = count + CNT_W'(push) - CNT_W'(pop);
        push_e.valid    = 1'b1;
        push_e.is_store = iss_is_store;
        push_e.base     = iss_base;
        push_e.base_tag = iss_base_tag;
        push_e.data     = iss_data;
        push_e.data_tag = iss_data_tag;
        push_e.offset   = iss_offset;
        push_e.tag      = iss_tag;
        if (cdb_valid && (iss_base_tag != '0) && (iss_base_tag == cdb_tag)) begin
            push_e.base     = cdb_data;
            push_e.base_tag = '0;
        end
        if (cdb_valid && (iss_data_tag != '0) && (iss_data_tag == cdb_tag)) begin
            push_e.data     = cdb_data;
            push_e.data_tag = '0;
        end
    end

    // Queue storage, pointers, occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            iss_ready <= 1'b1;
            for (int i = 0; i < DEPTH; i++) q[PTR_W'(i)] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q[PTR_W'(i)].valid && cdb_valid) begin
                    if ((q[PTR_W'(i)].base_tag != '0) && (q[PTR_W'(i)].base_tag == cdb_tag)) begin
                        q[PTR_W'(i)].base     <= cdb_data;
                        q[PTR_W'(i)].base_tag <= '0;
                    end
                    if ((q[PTR_W'(i)].data_tag != '0) && (q[PTR_W'(i)].data_tag == cdb_tag)) begin
                        q[PTR_W'(i)].data     <= cdb_data;
                        q[PTR_W'(i)].data_tag <= '0;
                    end
                end
            end
            if (pop) begin
                q[head].valid <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            if (push) begin
                q[tail] <= push_e;
                tail    <= tail + PTR_W'(1);
            end
            count     <= count_nxt;
            iss_ready <= (count_nxt != CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (head_rdy) state_nxt = head_e.is_store ? ST_WR : LD_RD;
            ST_WR:   state_nxt = ST_WAIT;
            ST_WAIT: if (mem_fns) state_nxt = IDLE;
            LD_RD:   state_nxt = LD_OUT;
            LD_OUT:  if (out_grant) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered memory/result outputs, plus head pop
    always_comb begin
        wena_nxt  = 1'b0;
        addrs_nxt = mem_addrS;
        wdata_nxt = mem_wdata;
        addrl_nxt = mem_addrL;
        ov_nxt    = out_valid;
        otag_nxt  = out_tag;
        odata_nxt = out_data;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (head_rdy && head_e.is_store) begin
                    wena_nxt  = 1'b1;
                    addrs_nxt = ea_addr;
                    wdata_nxt = head_e.data;
                end else if (head_rdy) begin
                    addrl_nxt = ea_addr;
                end
            end
            ST_WAIT: pop = mem_fns;
            LD_RD: begin
                ov_nxt    = 1'b1;
                otag_nxt  = head_e.tag;
                odata_nxt = mem_rdata;
            end
            LD_OUT: begin
                if (out_grant) begin
                    pop    = 1'b1;
                    ov_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wena  <= 1'b0;
            mem_addrS <= '0;
            mem_wdata <= '0;
            mem_addrL <= '0;
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_data  <= '0;
        end else begin
            mem_wena  <= wena_nxt;
            mem_addrS <= addrs_nxt;
            mem_wdata <= wdata_nxt;
            mem_addrL <= addrl_nxt;
            out_valid <= ov_nxt;
            out_tag   <= otag_nxt;
            out_data  <= odata_nxt;
        end
    end

endmodule

// File: tb/tb_ls_queue.sv
// Directed bench for ls_queue: vector table of single ops plus hand sequences
// for operand wakeup, bypass, ordering, full/wrap and mid-op reset.
module tb_ls_queue;
    logic        clk, rst;
    logic        iss_valid, iss_ready, iss_is_store;
    logic [31:0] iss_base, iss_data;
    logic [3:0]  iss_base_tag, iss_data_tag, iss_tag;
    logic [15:0] iss_offset;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        mem_wena, mem_fns;
    logic [8:0]  mem_addrS, mem_addrL;
    logic [31:0] mem_wdata, mem_rdata;
    logic        out_valid, out_grant;
    logic [3:0]  out_tag;
    logic [31:0] out_data;
    logic [2:0]  count;

    int n_chk  = 0;
    int n_fail = 0;

    ls_queue #(.DEPTH(4), .TAG_W(4), .ADDR_W(9)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_is_store(iss_is_store),
        .iss_base(iss_base), .iss_base_tag(iss_base_tag),
        .iss_data(iss_data), .iss_data_tag(iss_data_tag),
        .iss_offset(iss_offset), .iss_tag(iss_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .mem_wena(mem_wena), .mem_addrS(mem_addrS), .mem_wdata(mem_wdata),
        .mem_addrL(mem_addrL), .mem_rdata(mem_rdata), .mem_fns(mem_fns),
        .out_valid(out_valid), .out_tag(out_tag), .out_data(out_data),
        .out_grant(out_grant), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word i resets to i; writes to address 0 are dropped, fns still follows
    logic [31:0] mem [512];
    assign mem_rdata = mem[mem_addrL];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_fns <= 1'b0;
            for (int i = 0; i < 512; i++) mem[i] <= 32'(i);
        end else begin
            mem_fns <= mem_wena;
            if (mem_wena && mem_addrS != 9'd0) mem[mem_addrS] <= mem_wdata;
        end
    end

    typedef struct {
        logic        st;
        logic [31:0] base;
        logic [15:0] off;
        logic [31:0] data;
        logic [3:0]  tag;
        logic [8:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic st, input logic [31:0] base, input logic [3:0] btag,
                         input logic [31:0] data, input logic [3:0] dtag,
                         input logic [15:0] off, input logic [3:0] tag);
        iss_valid = 1'b1; iss_is_store = st;
        iss_base = base; iss_base_tag = btag;
        iss_data = data; iss_data_tag = dtag;
        iss_offset = off; iss_tag = tag;
        tick();
        iss_valid = 1'b0;
    endtask

    task automatic wait_out(input string nm);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic grant();
        out_grant = 1'b1;
        tick();
        out_grant = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 32'h4,         16'h0001, 32'h0,         4'd3,  9'h005, 32'h5};
        vecs[1] = '{1'b0, 32'h100,       16'hFFFF, 32'h0,         4'd9,  9'h0FF, 32'hFF};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 16'h0002, 32'h0,         4'd1,  9'h001, 32'h1};
        vecs[3] = '{1'b0, 32'h1234_0200, 16'h0005, 32'h0,         4'd15, 9'h005, 32'h5};
        vecs[4] = '{1'b1, 32'h10,        16'h0020, 32'hDEAD_BEEF, 4'd0,  9'h030, 32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 32'h30,        16'h0000, 32'h0,         4'd2,  9'h030, 32'hDEAD_BEEF};
        vecs[6] = '{1'b1, 32'h0,         16'h0000, 32'h1234,      4'd0,  9'h000, 32'h1234};
        vecs[7] = '{1'b0, 32'h0,         16'h0000, 32'h0,         4'd4,  9'h000, 32'h0};

        rst = 1'b1; iss_valid = 1'b0; iss_is_store = 1'b0;
        iss_base = '0; iss_base_tag = '0; iss_data = '0; iss_data_tag = '0;
        iss_offset = '0; iss_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; out_grant = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("reset count", 32'(count), 32'd0);
        chk("reset iss_ready", 32'(iss_ready), 32'd1);
        chk("reset mem_wena", 32'(mem_wena), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset mem_addrL", 32'(mem_addrL), 32'd0);

        // Single ready ops, back to an empty queue each time
        for (int v = 0; v < 8; v++) begin
            issue(vecs[v].st, vecs[v].base, 4'd0, vecs[v].data, 4'd0, vecs[v].off, vecs[v].tag);
            chk($sformatf("v%0d count after push", v), 32'(count), 32'd1);
            tick();
            if (vecs[v].st) begin
                chk($sformatf("v%0d wena", v), 32'(mem_wena), 32'd1);
                chk($sformatf("v%0d addrS", v), 32'(mem_addrS), 32'(vecs[v].exp_addr));
                chk($sformatf("v%0d wdata", v), mem_wdata, vecs[v].exp_data);
                tick();
                chk($sformatf("v%0d wena pulse end", v), 32'(mem_wena), 32'd0);
                chk($sformatf("v%0d count before fns", v), 32'(count), 32'd1);
                tick();
                chk($sformatf("v%0d count after fns", v), 32'(count), 32'd0);
            end else begin
                chk($sformatf("v%0d addrL", v), 32'(mem_addrL), 32'(vecs[v].exp_addr));
                chk($sformatf("v%0d early valid", v), 32'(out_valid), 32'd0);
                tick();
                chk($sformatf("v%0d out_valid", v), 32'(out_valid), 32'd1);
                chk($sformatf("v%0d out_tag", v), 32'(out_tag), 32'(vecs[v].tag));
                chk($sformatf("v%0d out_data", v), out_data, vecs[v].exp_data);
                tick();
                chk($sformatf("v%0d hold valid", v), 32'(out_valid), 32'd1);
                chk($sformatf("v%0d hold data", v), out_data, vecs[v].exp_data);
                grant();
                chk($sformatf("v%0d valid after grant", v), 32'(out_valid), 32'd0);
                chk($sformatf("v%0d count after grant", v), 32'(count), 32'd0);
            end
        end

        // Store waiting on base (tag 2) and data (tag 7); unrelated tag 9 first
        issue(1'b1, 32'h0, 4'd2, 32'h0, 4'd7, 16'h0000, 4'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'h55;
        tick();
        cdb_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("wait store no write", 32'(mem_wena), 32'd0);
            tick();
        end
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'h10;
        tick();
        chk("wait store still blocked", 32'(mem_wena), 32'd0);
        cdb_tag = 4'd7; cdb_data = 32'hABCD;
        tick();
        cdb_valid = 1'b0;
        tick();
        chk("wait store wena", 32'(mem_wena), 32'd1);
        chk("wait store addrS", 32'(mem_addrS), 32'h10);
        chk("wait store wdata", mem_wdata, 32'hABCD);
        tick();
        chk("wait store single pulse", 32'(mem_wena), 32'd0);
        tick();
        chk("wait store popped", 32'(count), 32'd0);
        chk("wait store memory", mem[9'h10], 32'hABCD);

        // Same-cycle bypass of the base operand at issue
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'h4;
        issue(1'b0, 32'h999, 4'd5, 32'h0, 4'd0, 16'h0001, 4'd6);
        cdb_valid = 1'b0; cdb_tag = 4'd0; cdb_data = 32'h0;
        tick();
        chk("bypass addrL", 32'(mem_addrL), 32'd5);
        tick();
        chk("bypass out_valid", 32'(out_valid), 32'd1);
        chk("bypass out_tag", 32'(out_tag), 32'd6);
        chk("bypass out_data", out_data, 32'h5);
        grant();
        chk("bypass count", 32'(count), 32'd0);

        // Program order: load to [6] waits for the store's finish
        issue(1'b1, 32'h0, 4'd0, 32'h77, 4'd0, 16'h0006, 4'd0);
        issue(1'b0, 32'h6, 4'd0, 32'h0, 4'd0, 16'h0000, 4'd8);
        chk("order store wena", 32'(mem_wena), 32'd1);
        chk("order count 2", 32'(count), 32'd2);
        tick();
        tick();
        chk("order store popped", 32'(count), 32'd1);
        chk("order load not started", 32'(mem_addrL), 32'd5);
        tick();
        chk("order load addrL", 32'(mem_addrL), 32'd6);
        tick();
        chk("order load valid", 32'(out_valid), 32'd1);
        chk("order load data", out_data, 32'h77);
        chk("order load tag", 32'(out_tag), 32'd8);
        grant();
        chk("order count 0", 32'(count), 32'd0);

        // Fill with blocked loads, reject a fifth, then release and drain
        for (int k = 0; k < 4; k++)
            issue(1'b0, 32'h0, 4'd10, 32'h0, 4'd0, 16'(k), 4'(k + 1));
        chk("full count", 32'(count), 32'd4);
        chk("full iss_ready", 32'(iss_ready), 32'd0);
        issue(1'b0, 32'h0, 4'd0, 32'h0, 4'd0, 16'h0000, 4'd9);
        chk("full reject", 32'(count), 32'd4);
        chk("full no start", 32'(out_valid), 32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd10; cdb_data = 32'h40;
        tick();
        cdb_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_out($sformatf("full drain %0d", k));
            chk($sformatf("full drain %0d tag", k), 32'(out_tag), 32'(k + 1));
            chk($sformatf("full drain %0d data", k), out_data, 32'h40 + 32'(k));
            grant();
        end
        for (int k = 0; k < 3; k++)
            issue(1'b0, 32'h50 + 32'(k), 4'd0, 32'h0, 4'd0, 16'h0000, 4'(k + 5));
        for (int k = 0; k < 3; k++) begin
            wait_out($sformatf("wrap drain %0d", k));
            chk($sformatf("wrap drain %0d tag", k), 32'(out_tag), 32'(k + 5));
            chk($sformatf("wrap drain %0d data", k), out_data, 32'h50 + 32'(k));
            grant();
        end
        chk("wrap count 0", 32'(count), 32'd0);
        chk("wrap iss_ready", 32'(iss_ready), 32'd1);

        // Asynchronous reset while a store is in its write cycle
        issue(1'b1, 32'h20, 4'd0, 32'h99, 4'd0, 16'h0000, 4'd0);
        issue(1'b0, 32'h21, 4'd0, 32'h0, 4'd0, 16'h0000, 4'd3);
        chk("rst pre wena", 32'(mem_wena), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst wena", 32'(mem_wena), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst count", 32'(count), 32'd0);
        chk("rst iss_ready", 32'(iss_ready), 32'd1);
        chk("rst addrS", 32'(mem_addrS), 32'd0);
        chk("rst wdata", mem_wdata, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        tick();
        chk("rst no restart wena", 32'(mem_wena), 32'd0);
        chk("rst no restart valid", 32'(out_valid), 32'd0);
        chk("rst stays empty", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ls_queue.md
# ls_queue

In-order load/store queue for the Tomasulo core, sitting directly upstream of the data memory. It accepts memory ops from issue, snoops the common data bus (CDB) for outstanding base and store-data operands, and forms effective addresses. It presents one op at a time to the memory: stores through a write/finish handshake, loads through a combinational read port. Load results go back to the CDB arbiter.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- TAG_W, 4, reservation-station tag width; tag 0 means "value present, no producer"
- ADDR_W, 9, memory word-address width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- iss_valid  in  1  issue request
- iss_ready  out  1  queue can accept (count != DEPTH)
- iss_is_store  in  1  1 = store, 0 = load
- iss_base / iss_base_tag  in  32 / TAG_W  base register value / producer tag
- iss_data / iss_data_tag  in  32 / TAG_W  store data / producer tag (ignored for loads)
- iss_offset  in  16  signed immediate
- iss_tag  in  TAG_W  destination tag broadcast with load result
- cdb_valid, cdb_tag, cdb_data  in  1, TAG_W, 32  CDB snoop
- mem_wena  out  1  memory write enable
- mem_addrS  out  ADDR_W  store word address
- mem_wdata  out  32  store data
- mem_addrL  out  ADDR_W  load word address
- mem_rdata  in  32  combinational read data for mem_addrL
- mem_fns  in  1  memory write-finish, high the cycle after a sampled write
- out_valid / out_tag / out_data  out  1 / TAG_W / 32  load result to CDB arbiter
- out_grant  in  1  arbiter accepts result this cycle
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Circular buffer with head/tail pointers. Pointer wrap is modulo DEPTH. Push happens when iss_valid && iss_ready; pop happens only as the FSM completes the head.
- Each entry holds valid, is_store, base, base_tag, data, data_tag, offset, tag.
- Snoop: every valid entry whose nonzero base_tag or data_tag equals cdb_tag while cdb_valid is high captures cdb_data and clears that tag.
  - A pushing entry snoops the same cycle: if an issue tag matches the live CDB, the value is written and the tag is stored as 0.
  - cdb_tag 0 never matches.
- Head ready: valid && base_tag==0 && (!is_store || data_tag==0).
- EA = base + sign_extend(offset), 32-bit, wrap on overflow. Memory address = EA[ADDR_W-1:0] (word index). Upper bits are ignored.
- FSM:
  - IDLE: if head ready and store → register mem_addrS, mem_wdata, mem_wena=1, go ST_WR. If head ready and load → register mem_addrL, go LD_RD. Otherwise stay.
  - ST_WR: mem_wena=0 (exactly one write cycle), go ST_WAIT.
  - ST_WAIT: on mem_fns=1 pop head, go IDLE.
  - LD_RD: capture mem_rdata into out_data, out_tag=head.tag, out_valid=1, go LD_OUT.
  - LD_OUT: hold out_* stable. On out_grant pop head, out_valid=0, go IDLE.
- Strict program order: no op overtakes the head, so no memory disambiguation is needed.
- Stores to address 0 are issued normally. The memory discards the write but still asserts fns.

## Timing
- Reset (async, immediate): head=tail=count=0, all entries invalid, FSM=IDLE, mem_wena=0, mem_addrS=0, mem_addrL=0, mem_wdata=0, out_valid=0, out_tag=0, out_data=0.
- Push → entry visible to the IDLE check at the following edge. Minimum issue-to-start latency is 1 cycle.
- Store: mem_wena is high for exactly one cycle, starting 1 edge after the IDLE decision. Memory samples it at the next edge, and fns is seen the cycle after. The entry pops 3 edges after the decision. One store completes per 3 cycles minimum.
- Load: out_valid rises 2 edges after the IDLE decision. With immediate grant, the entry pops at the third edge.
- Simultaneous push and pop: both take effect and count is unchanged. iss_ready does not account for a same-cycle pop, so a full queue rejects issue even while popping.
- A CDB match on a non-head entry while the head is executing updates that entry without disturbing the FSM.
- Reset mid-operation aborts immediately: mem_wena drops, any pending result is discarded, the queue empties.

## Test plan
- Reset: assert rst mid-store (ST_WR) → mem_wena=0, out_valid=0, count=0, iss_ready=1 within the same cycle.
- Ready load: memory word 5 = 0x5. Issue load base=4, offset=1, tags 0, iss_tag=3 → mem_addrL=5; out_valid=1, out_tag=3, out_data=0x5 two edges after start; hold until out_grant; count returns to 0.
- Waiting store: issue store base_tag=2, data_tag=7, offset=0. Then CDB tag 2 data 0x10, then tag 7 data 0xABCD → single mem_wena pulse with addrS=0x10, wdata=0xABCD; pop after mem_fns.
- Same-cycle bypass: issue with iss_base_tag=5 while cdb_valid, cdb_tag=5, cdb_data=4 → entry stores base=4, tag 0; executes without further CDB traffic.
- Order: store [6]=0x77, then load [6] → load observes 0x77 and starts only after the store's mem_fns.
- Full/wrap: issue 4 blocked loads → iss_ready=0, count=4. Release and grant all, then issue 3 more → pointers wrap; results return in issue order with correct tags.
